// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: panel geometry, pixel type and FSM encoding shared by the frame buffer.
package frame_buf_pkg;
    localparam int COLS      = 64;
    localparam int ROWS      = 32;
    localparam int PIX_W     = 12;
    localparam int WR_ADDR_W = 11;
    localparam int RD_ADDR_W = 10;
    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fb_state_t;
    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/frame_buf_if.sv
// frame_buf_if: renderer write port, swap/clear control and dspl_ctrl read port.
interface frame_buf_if;
    import frame_buf_pkg::*;
    logic                 wr_en;
    logic [WR_ADDR_W-1:0] wr_addr;
    pixel_t               wr_data;
    logic                 wr_rdy;
    logic                 swap_req;
    logic                 clear_req;
    logic                 swap_done;
    logic [RD_ADDR_W-1:0] r_addr;
    pixel_t               din_top;
    pixel_t               din_btm;
    modport master (
        output wr_en, wr_addr, wr_data, swap_req, clear_req, r_addr,
        input  wr_rdy, swap_done, din_top, din_btm
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, clear_req, r_addr,
        output wr_rdy, swap_done, din_top, din_btm
    );
endinterface

// File: rtl/frame_buf_ram.sv
// frame_buf_ram: one half-panel simple dual-port RAM with a registered, resettable read port.
module frame_buf_ram
    import frame_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [RD_ADDR_W-1:0] i_waddr,
    input  pixel_t               i_wdata,
    input  logic [RD_ADDR_W-1:0] i_raddr,
    output pixel_t               o_rdata
);
    pixel_t r_mem [COLS*ROWS/2];
    pixel_t r_q;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_q <= rst ? '0 : r_mem[i_raddr];
    end
    assign o_rdata = r_q;
endmodule

// File: rtl/frame_buf.sv
// frame_buf: double-buffered 64x32 RGB444 frame store; swaps commit only on the
// display row 15->0 wrap, and a hardware clear blanks the back bank.
module frame_buf
    import frame_buf_pkg::*;
(
    input logic        clk,
    input logic        rst,
    frame_buf_if.slave bus
);
    fb_state_t            r_state;
    logic                 r_front;
    logic                 r_swap_pend;
    logic                 r_wr_rdy;
    logic                 r_rd_sel;
    logic [WR_ADDR_W-1:0] r_clr_cnt;
    logic [3:0]           r_prev_row;
    logic                 w_clr;
    logic                 w_bnd;
    logic                 w_swap;
    logic                 w_we;
    logic                 w_pend;
    logic [WR_ADDR_W-1:0] w_waddr;
    pixel_t               w_wdata;
    pixel_t               w_q [2][2];

    assign w_clr   = r_state == CLEAR;
    assign w_bnd   = r_prev_row == 4'hF && bus.r_addr[9:6] == 4'h0;
    assign w_swap  = r_state == SWAP_WAIT && w_bnd;
    assign w_pend  = r_swap_pend || bus.swap_req;
    assign w_we    = !rst && (w_clr || (bus.wr_en && r_wr_rdy));
    assign w_waddr = w_clr ? r_clr_cnt : bus.wr_addr;
    assign w_wdata = w_clr ? '0 : bus.wr_data;

    assign bus.wr_rdy    = r_wr_rdy;
    assign bus.swap_done = w_swap;
    assign bus.din_top   = w_q[r_rd_sel][0];
    assign bus.din_btm   = w_q[r_rd_sel][1];

    // w_q[bank][half]; writes always land in the bank opposite r_front
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            frame_buf_ram u_ram (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_we && r_front != 1'(b) && w_waddr[10] == 1'(h)),
                .i_waddr (w_waddr[9:0]),
                .i_wdata (w_wdata),
                .i_raddr (bus.r_addr),
                .o_rdata (w_q[b][h])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_wr_rdy    <= 1'b1;
            r_rd_sel    <= 1'b0;
            r_clr_cnt   <= '0;
            r_prev_row  <= '0;
        end else begin
            r_prev_row <= bus.r_addr[9:6];
            r_rd_sel   <= r_front ^ w_swap;
            case (r_state)
                IDLE: begin
                    if (bus.clear_req) begin
                        r_state     <= CLEAR;
                        r_clr_cnt   <= '0;
                        r_swap_pend <= bus.swap_req;
                        r_wr_rdy    <= 1'b0;
                    end else if (bus.swap_req) begin
                        r_state  <= SWAP_WAIT;
                        r_wr_rdy <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_clr_cnt   <= r_clr_cnt + 11'd1;
                    r_swap_pend <= w_pend;
                    if (r_clr_cnt == '1) begin
                        r_state     <= w_pend ? SWAP_WAIT : IDLE;
                        r_wr_rdy    <= !w_pend;
                        r_swap_pend <= 1'b0;
                    end
                end
                SWAP_WAIT: begin
                    if (w_bnd) begin
                        r_state  <= IDLE;
                        r_front  <= !r_front;
                        r_wr_rdy <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_buf.sv
// tb_frame_buf: directed test-plan sequences plus a long randomized run, all checked
// against a bank-array reference model of the double-buffered frame store.
module tb_frame_buf;
    import frame_buf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    frame_buf_if bus();
    frame_buf dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int         n_chk, n_fail, n_sd, rpos, sd0;
    bit         chk_en, e_ok, park;
    pixel_t     e_top, e_btm;
    pixel_t     m_mem   [2][2048];
    bit         m_known [2][2048];
    bit         m_front, m_swap_pend, m_swap_wait;
    int         m_clr_left;
    logic [3:0] m_prev_row;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each bank is a flat 2048-pixel array; a clear is a countdown of
    // remaining pixels, a swap is a flag waiting for the row 15->0 wrap.
    task automatic model();
        bit bnd, nf;
        int a;
        if (rst) begin
            m_front = 0; m_swap_pend = 0; m_swap_wait = 0; m_clr_left = 0; m_prev_row = 0;
            e_ok = 1; e_top = 0; e_btm = 0; chk_en = 1;
            return;
        end
        bnd   = m_prev_row == 4'hF && bus.r_addr[9:6] == 4'h0;
        nf    = m_front ^ (m_swap_wait && bnd);
        e_ok  = m_known[nf][{1'b0, bus.r_addr}] && m_known[nf][{1'b1, bus.r_addr}];
        e_top = m_mem[nf][{1'b0, bus.r_addr}];
        e_btm = m_mem[nf][{1'b1, bus.r_addr}];
        if (m_clr_left > 0) begin
            a = 2048 - m_clr_left;
            m_mem[!m_front][a] = '0;
            m_known[!m_front][a] = 1;
            m_clr_left--;
            m_swap_pend |= bus.swap_req;
            if (m_clr_left == 0) begin
                m_swap_wait = m_swap_pend;
                m_swap_pend = 0;
            end
        end else if (m_swap_wait) begin
            if (bnd) begin
                m_swap_wait = 0;
                m_front = nf;
            end
        end else begin
            if (bus.wr_en) begin
                m_mem[!m_front][bus.wr_addr] = bus.wr_data;
                m_known[!m_front][bus.wr_addr] = 1;
            end
            if (bus.clear_req) begin
                m_clr_left = 2048;
                m_swap_pend = bus.swap_req;
            end else m_swap_wait = bus.swap_req;
        end
        m_prev_row = bus.r_addr[9:6];
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.swap_done === 1'b1) n_sd++;
        if (chk_en) begin
            check("wr_rdy", bus.wr_rdy, m_clr_left == 0 && !m_swap_wait);
            check("swap_done", bus.swap_done,
                  m_swap_wait && m_prev_row == 4'hF && bus.r_addr[9:6] == 4'h0);
            if (e_ok) begin
                check("din_top", bus.din_top, e_top);
                check("din_btm", bus.din_btm, e_btm);
            end
        end
        @(posedge clk);
        model();
        #1;
    endtask

    task automatic cyc();
        if (!park) begin
            bus.r_addr = 10'(rpos);
            rpos = (rpos + 1) % 1024;
        end
        step();
        bus.wr_en = 0; bus.swap_req = 0; bus.clear_req = 0;
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while (!(m_clr_left == 0 && !m_swap_wait) && n < budget) begin
            cyc();
            n++;
        end
        check("idle", bus.wr_rdy, 1'b1);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.swap_req = 0; bus.clear_req = 0; bus.r_addr = 0;
        repeat (2) cyc();
        rst = 0;
        check("rst_rdy", bus.wr_rdy, 1'b1);
        check("rst_sd", bus.swap_done, 1'b0);
        check("rst_top", bus.din_top, 12'h000);
        check("rst_btm", bus.din_btm, 12'h000);

        // clear+swap together, then a plain clear: both banks become black
        bus.clear_req = 1; bus.swap_req = 1; cyc();
        wait_idle(5000);
        bus.clear_req = 1; cyc();
        wait_idle(3000);

        for (int a = 0; a < 2048; a++) begin
            bus.wr_en = 1; bus.wr_addr = a[10:0]; bus.wr_data = a[11:0];
            cyc();
        end

        park = 1; bus.r_addr = 10'(5 * 64); bus.swap_req = 1; sd0 = n_sd;
        cyc();
        repeat (50) cyc();
        check("hold_rdy", bus.wr_rdy, 1'b0);
        check("hold_top", bus.din_top, 12'h000);
        park = 0; rpos = 14 * 64;
        wait_idle(3000);
        check("swap_once", n_sd - sd0, 1);

        park = 1;
        for (int i = 0; i < 1024; i++) begin
            bus.r_addr = 10'(i);
            cyc();
            check("pat_top", bus.din_top, 12'(i));
            check("pat_btm", bus.din_btm, 12'(1024 + i));
        end

        bus.r_addr = 0; bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 12'hFFF; cyc();
        bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 12'hFFF; cyc();
        bus.r_addr = 1; cyc();
        check("front_keep", bus.din_top, 12'h001);
        park = 0; rpos = 0; bus.swap_req = 1; cyc();
        wait_idle(3000);
        park = 1; bus.r_addr = 0; cyc();
        check("swapped", bus.din_top, 12'hFFF);

        park = 0; bus.clear_req = 1; bus.swap_req = 1; cyc();
        repeat (100) cyc();
        rst = 1; cyc(); rst = 0;
        check("mid_rdy", bus.wr_rdy, 1'b1);
        check("mid_sd", bus.swap_done, 1'b0);
        check("mid_top", bus.din_top, 12'h000);
        check("mid_btm", bus.din_btm, 12'h000);
        sd0 = n_sd;
        repeat (2100) cyc();
        check("no_swap", n_sd - sd0, 0);

        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 63) == 0) rpos = $urandom_range(0, 1023);
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = 11'($urandom);
            bus.wr_data   = 12'($urandom);
            bus.swap_req  = $urandom_range(0, 299) == 0;
            bus.clear_req = $urandom_range(0, 1999) == 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
